timx_apb_init_seq: RTL and testbench
====================================

Name: timx_apb_init_seq

Overview:
APB master sequencer that programs apoip_timer registers from a small on-chip table of (address, data, verify) entries. On a start pulse it issues the entries in order as APB write transfers. Each flagged entry is then read back and compared. It sits between the SoC control logic and the timer's APB slave port, replacing software bring-up of ARR/CCRx/DIER/CCMRx/EGR/CCER/BDTR/CR1.

Parameters:
DEPTH, 16, number of table entries
IDX_W, 4, index width, equal to log2(DEPTH)
GAP_CYCLES, 0, idle cycles with psel low inserted after each completed APB access phase (0..15)

Ports:
apb_clk  input  1  clock; all logic is on the rising edge
apb_rst_n  input  1  asynchronous active-low reset
cfg_wr_en  input  1  table write strobe; accepted only while seq_busy=0
cfg_wr_idx  input  IDX_W  table entry being written
cfg_wr_addr  input  16  timer register address for the entry
cfg_wr_data  input  32  write data for the entry
cfg_wr_vfy  input  1  1 = read back and compare after the write
cfg_num  input  IDX_W+1  number of entries to run (0..DEPTH); sampled on start
seq_start  input  1  single-cycle start pulse
seq_abort  input  1  stop the sequence at the next transfer boundary
seq_busy  output  1  high from the cycle after an accepted start until the cycle done pulses
seq_done  output  1  one-cycle pulse on completion, error or abort
seq_err  output  1  verify mismatch; sticky until the next accepted start
seq_err_idx  output  IDX_W  index of the failing entry
timx_psel  output  1  APB select
timx_penable  output  1  APB enable
timx_pwrite  output  1  APB direction
timx_paddr  output  16  APB address
timx_pwdata  output  32  APB write data
timx_prdata  input  32  APB read data from the timer

Behaviour:
- Clock and reset: one clock, apb_clk. Reset apb_rst_n is asynchronous and active-low.
- Reset values: all outputs are 0; the FSM is in IDLE; table contents are don't-care.
- All outputs are registered.
- The timer has no pready or pslverr. Every access is therefore exactly 2 cycles: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1).
- FSM states: IDLE, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS, GAP, FINISH.
- IDLE:
  - On seq_start with cfg_num>0: latch cfg_num, set idx=0, clear seq_err, go to W_SETUP next cycle.
  - On seq_start with cfg_num=0: go to FINISH. seq_done pulses 1 cycle after start, with no bus activity.
- W_SETUP: drive the entry's paddr/pwdata with pwrite=1, then go to W_ACCESS.
- W_ACCESS: after this cycle, go to R_SETUP if the entry's vfy=1. Otherwise advance.
- R_SETUP: same paddr, pwrite=0, pwdata held.
- R_ACCESS: sample timx_prdata at the end of this cycle and compare all 32 bits with the table data.
  - Mismatch: seq_err=1, seq_err_idx=idx, go to FINISH.
  - Match: advance.
- Advance:
  - If idx+1 == latched count, go to FINISH.
  - Else if GAP_CYCLES>0, go to GAP for GAP_CYCLES cycles with psel=0, then W_SETUP.
  - Else go directly to W_SETUP with no psel-low cycle.
- FINISH: lasts 1 cycle. seq_done=1, seq_busy=0 in the same cycle, psel=0. Next state is IDLE.
- seq_abort:
  - Sampled in any busy state.
  - A SETUP phase always proceeds to its ACCESS phase, as APB requires.
  - After that ACCESS, or immediately if in GAP, the FSM goes to FINISH.
  - A pending verify read for the current entry is skipped.
  - Abort in IDLE is ignored.
- seq_start while busy is ignored.
- cfg_wr_en while busy is ignored, so the table stays stable during a run.
- If seq_start and cfg_wr_en arrive in the same IDLE cycle, the table write takes effect and the sequence uses the new entry.
- Between transfers, paddr and pwdata hold their last values; pwrite returns to 0 in FINISH.
- A reset in the middle of a transfer returns to IDLE immediately with psel=0. The timer sees the transfer aborted.
- Verify is the user's choice per entry. Entries for self-clearing registers (EGR) must use vfy=0.

Test Plan:
1. Standard init, vfy=0, cfg_num=8:
   - Entries: 0x2C=0x8, 0x34=0x4, 0x0C=0x3, 0x18=0x68, 0x14=0x1, 0x20=0x5, 0x44=0x8C00, 0x00=0xA1.
   - Required: 16 consecutive psel-high cycles with penable alternating 0/1 and addresses in that order.
   - seq_done pulses the cycle after the 8th ACCESS; seq_err=0. The timer then toggles timx_ch1_out with period 9 and CC1 at 4.
2. Same table with vfy=1 on entries 0 (ARR) and 3 (CCMR1):
   - Required: read transfers appear after those writes; total 20 psel cycles.
   - With the real timer, done occurs with seq_err=0.
   - With the bench forcing prdata=0 during the entry-3 read, seq_err=1 and seq_err_idx=3; entries 4..7 are never issued.
3. cfg_num=0 and start:
   - Required: seq_done 1 cycle later, psel stays 0, seq_busy never asserts.
4. Abort during the W_SETUP of entry 2:
   - Required: entry 2's W_ACCESS completes, then FINISH; entries 3..7 are not issued.
   - seq_start pulsed again while busy is ignored.
5. GAP_CYCLES=3, cfg_num=2:
   - Required: exactly 3 psel-low cycles between the first ACCESS and the second SETUP.
   - seq_done occurs 8 cycles after start.
6. Assert apb_rst_n=0 asynchronously during the R_ACCESS of entry 0:
   - Required: all outputs go to 0 immediately.
   - After release, a fresh start replays from entry 0 with the table intact.

Source files
------------

// File: rtl/timx_apb_init_seq_if.sv
// APB bus between the init sequencer and the timer slave port.
// No pready/pslverr: every access is a fixed two-cycle transfer.
interface timx_apb_init_seq_if;
  logic        timx_psel;
  logic        timx_penable;
  logic        timx_pwrite;
  logic [15:0] timx_paddr;
  logic [31:0] timx_pwdata;
  logic [31:0] timx_prdata;

  modport master (
    output timx_psel,
    output timx_penable,
    output timx_pwrite,
    output timx_paddr,
    output timx_pwdata,
    input  timx_prdata
  );

  modport slave (
    input  timx_psel,
    input  timx_penable,
    input  timx_pwrite,
    input  timx_paddr,
    input  timx_pwdata,
    output timx_prdata
  );
endinterface

// File: rtl/timx_apb_init_seq.sv
// Table-driven APB master that programs timer registers after reset,
// with optional read-back verify per entry.
module timx_apb_init_seq #(
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             apb_clk,
  input  logic             apb_rst_n,
  input  logic             cfg_wr_en,
  input  logic [IDX_W-1:0] cfg_wr_idx,
  input  logic [15:0]      cfg_wr_addr,
  input  logic [31:0]      cfg_wr_data,
  input  logic             cfg_wr_vfy,
  input  logic [IDX_W:0]   cfg_num,
  input  logic             seq_start,
  input  logic             seq_abort,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_err,
  output logic [IDX_W-1:0] seq_err_idx,
  timx_apb_init_seq_if.master apb
);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_ACCESS,
    R_SETUP,
    R_ACCESS,
    GAP,
    FINISH
  } state_t;

  localparam int GAP_M1 =
    (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [15:0] tbl_addr [DEPTH];
  logic [31:0] tbl_data [DEPTH];
  logic        tbl_vfy  [DEPTH];

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W:0]   cnt, cnt_nxt;
  logic [3:0]       gap, gap_nxt;
  logic             abt, abt_nxt;
  logic             err_nxt;
  logic [IDX_W-1:0] eidx_nxt;
  logic             abt_req;
  logic             adv;
  logic             last;
  logic             busy_st;
  logic             wr_ok;
  logic [15:0]      ent_addr;
  logic [31:0]      ent_data;
  logic             psel_nxt;
  logic             pen_nxt;
  logic             pwr_nxt;
  logic [15:0]      paddr_nxt;
  logic [31:0]      pwdata_nxt;

  assign busy_st = (state != IDLE) &&
                   (state != FINISH);
  assign wr_ok   = cfg_wr_en && !busy_st;
  assign abt_req = abt || seq_abort;
  assign last    = ({1'b0, idx} +
                    (IDX_W+1)'(1)) == cnt;

  // Table storage; no reset so contents survive a mid-run reset.
  always_ff @(posedge apb_clk) begin
    if (wr_ok) begin
      tbl_addr[cfg_wr_idx] <= cfg_wr_addr;
      tbl_data[cfg_wr_idx] <= cfg_wr_data;
      tbl_vfy[cfg_wr_idx]  <= cfg_wr_vfy;
    end
  end

  // Next state, entry index, abort latch and verify result.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    gap_nxt   = gap;
    abt_nxt   = abt;
    err_nxt   = seq_err;
    eidx_nxt  = seq_err_idx;
    adv       = 1'b0;
    unique case (state)
      IDLE: begin
        abt_nxt = 1'b0;
        if (seq_start) begin
          err_nxt  = 1'b0;
          eidx_nxt = '0;
          if (cfg_num != '0) begin
            cnt_nxt   = cfg_num;
            idx_nxt   = '0;
            state_nxt = W_SETUP;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      W_SETUP: begin
        abt_nxt   = abt_req;
        state_nxt = W_ACCESS;
      end
      W_ACCESS: begin
        if (abt_req)
          state_nxt = FINISH;
        else if (tbl_vfy[idx])
          state_nxt = R_SETUP;
        else
          adv = 1'b1;
      end
      R_SETUP: begin
        abt_nxt   = abt_req;
        state_nxt = R_ACCESS;
      end
      R_ACCESS: begin
        if (apb.timx_prdata != tbl_data[idx]) begin
          err_nxt   = 1'b1;
          eidx_nxt  = idx;
          state_nxt = FINISH;
        end else if (abt_req) begin
          state_nxt = FINISH;
        end else begin
          adv = 1'b1;
        end
      end
      GAP: begin
        if (abt_req)
          state_nxt = FINISH;
        else if (gap == 4'd0)
          state_nxt = W_SETUP;
        else
          gap_nxt = gap - 4'd1;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (adv) begin
      if (last) begin
        state_nxt = FINISH;
      end else begin
        idx_nxt = idx + IDX_W'(1);
        if (GAP_CYCLES > 0) begin
          state_nxt = GAP;
          gap_nxt   = 4'(GAP_M1);
        end else begin
          state_nxt = W_SETUP;
        end
      end
    end
  end

  // Entry fetch; a same-cycle table write wins over stored data.
  always_comb begin
    ent_addr = tbl_addr[idx_nxt];
    ent_data = tbl_data[idx_nxt];
    if (wr_ok && cfg_wr_idx == idx_nxt) begin
      ent_addr = cfg_wr_addr;
      ent_data = cfg_wr_data;
    end
  end

  // Bus outputs for the upcoming cycle, decoded from next state.
  always_comb begin
    psel_nxt   = 1'b0;
    pen_nxt    = 1'b0;
    pwr_nxt    = apb.timx_pwrite;
    paddr_nxt  = apb.timx_paddr;
    pwdata_nxt = apb.timx_pwdata;
    unique case (1'b1)
      (state_nxt == W_SETUP): begin
        psel_nxt   = 1'b1;
        pwr_nxt    = 1'b1;
        paddr_nxt  = ent_addr;
        pwdata_nxt = ent_data;
      end
      (state_nxt == W_ACCESS): begin
        psel_nxt = 1'b1;
        pen_nxt  = 1'b1;
      end
      (state_nxt == R_SETUP): begin
        psel_nxt = 1'b1;
        pwr_nxt  = 1'b0;
      end
      (state_nxt == R_ACCESS): begin
        psel_nxt = 1'b1;
        pen_nxt  = 1'b1;
      end
      (state_nxt == FINISH): pwr_nxt = 1'b0;
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      cnt              <= '0;
      gap              <= '0;
      abt              <= 1'b0;
      seq_busy         <= 1'b0;
      seq_done         <= 1'b0;
      seq_err          <= 1'b0;
      seq_err_idx      <= '0;
      apb.timx_psel    <= 1'b0;
      apb.timx_penable <= 1'b0;
      apb.timx_pwrite  <= 1'b0;
      apb.timx_paddr   <= '0;
      apb.timx_pwdata  <= '0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      cnt              <= cnt_nxt;
      gap              <= gap_nxt;
      abt              <= abt_nxt;
      seq_busy         <= (state_nxt != IDLE) &&
                          (state_nxt != FINISH);
      seq_done         <= state_nxt == FINISH;
      seq_err          <= err_nxt;
      seq_err_idx      <= eidx_nxt;
      apb.timx_psel    <= psel_nxt;
      apb.timx_penable <= pen_nxt;
      apb.timx_pwrite  <= pwr_nxt;
      apb.timx_paddr   <= paddr_nxt;
      apb.timx_pwdata  <= pwdata_nxt;
    end
  end

endmodule

// File: tb/tb_timx_apb_init_seq.sv
// Bench for timx_apb_init_seq: two instances (no gap, 3-cycle gap)
// checked against a queue-of-bus-cycles model plus literal checks.
module tb_timx_apb_init_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_idx = '0;
  logic [15:0] cfg_wr_addr = '0;
  logic [31:0] cfg_wr_data = '0;
  logic        cfg_wr_vfy = 1'b0;
  logic [4:0]  cfg_num = '0;
  logic        seq_start = 1'b0;
  logic        seq_abort = 1'b0;
  logic        busy [2];
  logic        done [2];
  logic        err  [2];
  logic [3:0]  eidx [2];
  logic        force_en = 1'b0;
  logic [15:0] force_addr = '0;
  logic [31:0] smem [2][256];
  logic [57:0] act_v [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timx_apb_init_seq_if bus0 ();
  timx_apb_init_seq_if bus3 ();

  timx_apb_init_seq #(.DEPTH(16), .IDX_W(4), .GAP_CYCLES(0)) dut0 (
    .apb_clk(clk), .apb_rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_vfy(cfg_wr_vfy), .cfg_num(cfg_num),
    .seq_start(seq_start), .seq_abort(seq_abort),
    .seq_busy(busy[0]), .seq_done(done[0]),
    .seq_err(err[0]), .seq_err_idx(eidx[0]),
    .apb(bus0.master)
  );

  timx_apb_init_seq #(.DEPTH(16), .IDX_W(4), .GAP_CYCLES(3)) dut3 (
    .apb_clk(clk), .apb_rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_vfy(cfg_wr_vfy), .cfg_num(cfg_num),
    .seq_start(seq_start), .seq_abort(seq_abort),
    .seq_busy(busy[1]), .seq_done(done[1]),
    .seq_err(err[1]), .seq_err_idx(eidx[1]),
    .apb(bus3.master)
  );

  // Simple timer register file behind each bus.
  assign bus0.timx_prdata =
    (force_en && bus0.timx_paddr == force_addr) ? 32'h0 :
    smem[0][bus0.timx_paddr[7:0]];
  assign bus3.timx_prdata =
    (force_en && bus3.timx_paddr == force_addr) ? 32'h0 :
    smem[1][bus3.timx_paddr[7:0]];

  always @(posedge clk) begin
    if (bus0.timx_psel && bus0.timx_penable && bus0.timx_pwrite)
      smem[0][bus0.timx_paddr[7:0]] <= bus0.timx_pwdata;
    if (bus3.timx_psel && bus3.timx_penable && bus3.timx_pwrite)
      smem[1][bus3.timx_paddr[7:0]] <= bus3.timx_pwdata;
  end

  assign act_v[0] = {bus0.timx_psel, bus0.timx_penable,
                     bus0.timx_pwrite, bus0.timx_paddr,
                     bus0.timx_pwdata, busy[0], done[0],
                     err[0], eidx[0]};
  assign act_v[1] = {bus3.timx_psel, bus3.timx_penable,
                     bus3.timx_pwrite, bus3.timx_paddr,
                     bus3.timx_pwdata, busy[1], done[1],
                     err[1], eidx[1]};

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  // ---------------- model: queue of expected bus cycles ----------
  typedef struct {
    bit          sel;
    bit          en;
    bit          wr;
    bit          busy;
    bit          fin;
    logic [15:0] a;
    logic [31:0] d;
    int          idx;
  } beat_t;

  beat_t       cur [2];
  beat_t       mq [2][$];
  logic        merr [2];
  logic [3:0]  meidx [2];
  bit          pend [2];
  logic [15:0] mt_a [2][16];
  logic [31:0] mt_d [2][16];
  bit          mt_v [2][16];
  logic [31:0] mm [2][256];

  function automatic beat_t mk(bit s, bit e, bit w, bit b, bit f,
                               logic [15:0] a, logic [31:0] d,
                               int i);
    beat_t r;
    r.sel = s; r.en = e; r.wr = w; r.busy = b; r.fin = f;
    r.a = a; r.d = d; r.idx = i;
    return r;
  endfunction

  function automatic logic [57:0] expv(input int k);
    beat_t c;
    c = cur[k];
    return {c.sel, c.en, c.wr, c.a, c.d, c.busy, c.fin,
            merr[k], meidx[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cur[k] = mk(0, 0, 0, 0, 0, 16'h0, 32'h0, 0);
      mq[k].delete();
      merr[k] = 1'b0;
      meidx[k] = 4'h0;
      pend[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    beat_t c;
    logic [31:0] rd;
    logic [15:0] la;
    logic [31:0] ld;
    bit lw;
    int n, g;
    c = cur[k];
    if (!c.busy && cfg_wr_en) begin
      mt_a[k][cfg_wr_idx] = cfg_wr_addr;
      mt_d[k][cfg_wr_idx] = cfg_wr_data;
      mt_v[k][cfg_wr_idx] = cfg_wr_vfy;
    end
    if (c.busy) begin
      if (c.sel && c.en && c.wr) mm[k][c.a[7:0]] = c.d;
      if (c.sel && c.en && !c.wr) begin
        rd = (force_en && c.a == force_addr) ? 32'h0 :
             mm[k][c.a[7:0]];
        if (rd !== c.d) begin
          merr[k] = 1'b1;
          meidx[k] = 4'(c.idx);
          mq[k].delete();
          mq[k].push_back(mk(0, 0, 0, 0, 1, c.a, c.d, 0));
        end
      end
      if (c.sel && !c.en) begin
        if (seq_abort) pend[k] = 1'b1;
      end else if (seq_abort || pend[k]) begin
        mq[k].delete();
        mq[k].push_back(mk(0, 0, 0, 0, 1, c.a, c.d, 0));
      end
    end else if (!c.fin && seq_start) begin
      merr[k] = 1'b0;
      meidx[k] = 4'h0;
      pend[k] = 1'b0;
      g = (k == 0) ? 0 : 3;
      n = int'(cfg_num);
      la = c.a;
      ld = c.d;
      for (int i = 0; i < n; i++) begin
        la = mt_a[k][i];
        ld = mt_d[k][i];
        mq[k].push_back(mk(1, 0, 1, 1, 0, la, ld, i));
        mq[k].push_back(mk(1, 1, 1, 1, 0, la, ld, i));
        lw = 1'b1;
        if (mt_v[k][i]) begin
          mq[k].push_back(mk(1, 0, 0, 1, 0, la, ld, i));
          mq[k].push_back(mk(1, 1, 0, 1, 0, la, ld, i));
          lw = 1'b0;
        end
        if (i < n - 1)
          for (int j = 0; j < g; j++)
            mq[k].push_back(mk(0, 0, lw, 1, 0, la, ld, i));
      end
      mq[k].push_back(mk(0, 0, 0, 0, 1, la, ld, 0));
    end
    if (mq[k].size() > 0) cur[k] = mq[k].pop_front();
    else cur[k] = mk(0, 0, 0, 0, 0, c.a, c.d, 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n)
        for (int k = 0; k < 2; k++)
          chk($sformatf("model dut%0d t=%0t", k, $time),
              act_v[k], expv(k));
    end
  end

  // ---------------- directed stimulus ----------------
  int          pc [2];
  int          gl [2];
  int          dn [2];
  bit          bz [2];
  logic [15:0] wa0 [$];
  logic [31:0] wd0;
  logic [15:0] ta [8];
  logic [31:0] td [8];

  task automatic wr(input int i, input logic [15:0] a,
                    input logic [31:0] d, input bit v);
    @(negedge clk);
    cfg_wr_en = 1'b1;
    cfg_wr_idx = 4'(i);
    cfg_wr_addr = a;
    cfg_wr_data = d;
    cfg_wr_vfy = v;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic go(input int num, input int ab, input int rs,
                    input bit w0);
    @(negedge clk);
    seq_start = 1'b1;
    cfg_num = 5'(num);
    if (w0) begin
      cfg_wr_en = 1'b1;
      cfg_wr_idx = 4'd0;
      cfg_wr_addr = 16'h002C;
      cfg_wr_data = 32'h8;
      cfg_wr_vfy = 1'b0;
    end
    wa0.delete();
    wd0 = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      pc[k] = 0; gl[k] = 0; dn[k] = -1; bz[k] = 1'b0;
    end
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus0.timx_psel) pc[0]++;
      if (bus3.timx_psel) pc[1]++;
      if (busy[0] && !bus0.timx_psel) gl[0]++;
      if (busy[1] && !bus3.timx_psel) gl[1]++;
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) bz[k] = 1'b1;
        if (done[k] && dn[k] < 0) dn[k] = i;
      end
      if (bus0.timx_psel && !bus0.timx_penable &&
          bus0.timx_pwrite) begin
        if (wa0.size() == 0) wd0 = bus0.timx_pwdata;
        wa0.push_back(bus0.timx_paddr);
      end
      if (dn[0] >= 0 && dn[1] >= 0) break;
      seq_start = (i == rs);
      seq_abort = (i == ab);
      cfg_wr_en = 1'b0;
    end
    seq_start = 1'b0;
    seq_abort = 1'b0;
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    ta[0] = 16'h2C; td[0] = 32'h8;
    ta[1] = 16'h34; td[1] = 32'h4;
    ta[2] = 16'h0C; td[2] = 32'h3;
    ta[3] = 16'h18; td[3] = 32'h68;
    ta[4] = 16'h14; td[4] = 32'h1;
    ta[5] = 16'h20; td[5] = 32'h5;
    ta[6] = 16'h44; td[6] = 32'h8C00;
    ta[7] = 16'h00; td[7] = 32'hA1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset bus", {bus0.timx_psel, bus0.timx_penable,
                      bus0.timx_pwrite}, 0);
    chk("reset status", {busy[0], done[0], err[0], eidx[0]}, 0);

    // Standard init; entry 0 rewritten in the start cycle.
    wr(0, 16'h2C, 32'hDEAD, 1'b0);
    for (int i = 1; i < 8; i++) wr(i, ta[i], td[i], 1'b0);
    go(8, 0, 0, 1'b1);
    chk("t1 psel cycles", pc[0], 16);
    chk("t1 done cycle", dn[0], 17);
    chk("t1 err", err[0], 0);
    chk("t1 first wdata", wd0, 32'h8);
    chk("t1 write count", wa0.size(), 8);
    for (int j = 0; j < 8; j++)
      chk($sformatf("t1 addr %0d", j),
          (j < wa0.size()) ? wa0[j] : 16'hFFFF, ta[j]);
    chk("t1 gap3 done cycle", dn[1], 38);
    chk("t1 gap3 idle cycles", gl[1], 21);

    // Zero-length run.
    go(0, 0, 0, 1'b0);
    chk("t3 done cycle", dn[0], 1);
    chk("t3 gap3 done cycle", dn[1], 1);
    chk("t3 psel cycles", pc[0] + pc[1], 0);
    chk("t3 busy seen", {bz[0], bz[1]}, 0);

    // Two entries with gap.
    go(2, 0, 0, 1'b0);
    chk("t5 gap3 done cycle", dn[1], 8);
    chk("t5 gap3 idle cycles", gl[1], 3);
    chk("t5 nogap done cycle", dn[0], 5);
    chk("t5 nogap idle cycles", gl[0], 0);

    // Abort in W_SETUP of entry 2, extra start ignored.
    go(8, 5, 3, 1'b0);
    chk("t4 done cycle", dn[0], 7);
    chk("t4 psel cycles", pc[0], 6);
    chk("t4 write count", wa0.size(), 3);
    chk("t4 last addr", wa0[wa0.size()-1], 16'h0C);
    chk("t4 gap3 done cycle", dn[1], 6);
    chk("t4 err", err[0], 0);

    // Verify on entries 0 and 3.
    wr(0, 16'h2C, 32'h8, 1'b1);
    wr(3, 16'h18, 32'h68, 1'b1);
    go(8, 0, 0, 1'b0);
    chk("t2 psel cycles", pc[0], 20);
    chk("t2 done cycle", dn[0], 21);
    chk("t2 err", err[0], 0);

    force_en = 1'b1;
    force_addr = 16'h18;
    go(8, 0, 0, 1'b0);
    chk("t2b err", err[0], 1);
    chk("t2b err idx", eidx[0], 3);
    chk("t2b psel cycles", pc[0], 12);
    chk("t2b done cycle", dn[0], 13);
    chk("t2b write count", wa0.size(), 4);
    chk("t2b gap3 err idx", {err[1], eidx[1]}, 5'h13);
    force_en = 1'b0;

    // Async reset during R_ACCESS of entry 0, then replay.
    @(negedge clk);
    seq_start = 1'b1;
    cfg_num = 5'd8;
    found = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      seq_start = 1'b0;
      if (bus0.timx_psel && bus0.timx_penable &&
          !bus0.timx_pwrite) begin
        found = i;
        break;
      end
    end
    chk("t6 read access cycle", found, 4);
    chk("t6 err cleared by start", err[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async reset dut0", act_v[0], 0);
    chk("t6 async reset dut3", act_v[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(8, 0, 0, 1'b0);
    chk("t6 replay psel cycles", pc[0], 20);
    chk("t6 replay first addr",
        (wa0.size() > 0) ? wa0[0] : 16'hFFFF, 16'h2C);
    chk("t6 replay done cycle", dn[0], 21);
    chk("t6 replay err", err[0], 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
